sextium_avalon_arbiter: RTL and testbench

- Two-requester Avalon-MM master arbiter in front of the single Sextium Avalon master port.
- Requester A is the CPU I/O bridge; requester B is a secondary master such as a debug or DMA loader.
- Round-robin grant per transaction. Master outputs are registered and held stable until waitrequest drops. The winner gets a one-cycle registered ack with captured readdata.

---
 rtl/sextium_avalon_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sextium_avalon_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sextium_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sextium_avalon_arbiter
// Description : Two-requester round-robin arbiter in front of the single
//               Sextium Avalon-MM master port. Requester A is the CPU I/O
//               bridge, requester B a secondary master (debug/DMA loader).
//               One transaction per grant, registered master outputs held
//               until waitrequest drops, one-cycle registered ack with the
//               captured read data.
//               Optional build macro SEXTIUM_ARB_TIMEOUT_EN adds a watchdog
//               that aborts a stalled transaction after TIMEOUT_CYCLES and
//               raises a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sextium_avalon_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   // requester A
   input  logic [ADDR_W-1:0] a_address,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [DATA_W-1:0] a_writedata,
   input  logic [3:0]        a_byteenable,
   output logic [DATA_W-1:0] a_readdata,
   output logic              a_ack,
   // requester B
   input  logic [ADDR_W-1:0] b_address,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [DATA_W-1:0] b_writedata,
   input  logic [3:0]        b_byteenable,
   output logic [DATA_W-1:0] b_readdata,
   output logic              b_ack,
   // Avalon master
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata,
   output logic [3:0]        byteenable,
   input  logic [DATA_W-1:0] readdata,
   input  logic              waitrequest,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic c_SEL_A = 1'b0;

   state_t            r_state;
   logic              r_ptr;      // requester favoured when both are pending
   logic              r_win;      // requester owning the current transaction
   logic              w_a_pend;
   logic              w_b_pend;
   logic              w_pick_b;
   logic              w_timeout;
   logic [DATA_W-1:0] w_capture;

   assign w_a_pend = a_read | a_write;
   assign w_b_pend = b_read | b_write;
   // B wins when it is the only one asking, or when both ask and it is B's turn
   assign w_pick_b = w_b_pend & (~w_a_pend | r_ptr);

   // Value returned to the winner: read data, zero for writes, all-ones on abort
   assign w_capture = w_timeout ? {DATA_W{1'b1}} : (read ? readdata : '0);

`ifdef SEXTIUM_ARB_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_err;

   assign w_timeout = (r_state == ST_BUSY) && waitrequest &&
                      (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
   assign err       = r_err;

   // Stall watchdog: counts BUSY cycles with waitrequest high; err is sticky
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state != ST_BUSY)
            r_cnt <= '0;
         else if (waitrequest && !w_timeout)
            r_cnt <= r_cnt + 1'b1;
         if (w_timeout)
            r_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   // Arbitration FSM driving the registered master port, acks and read data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= c_SEL_A;
         r_win      <= c_SEL_A;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         byteenable <= '0;
         a_readdata <= '0;
         b_readdata <= '0;
         a_ack      <= 1'b0;
         b_ack      <= 1'b0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_a_pend || w_b_pend) begin
                  // read+write together is issued as a plain read
                  address    <= w_pick_b ? b_address    : a_address;
                  read       <= w_pick_b ? b_read       : a_read;
                  write      <= w_pick_b ? (b_write & ~b_read) : (a_write & ~a_read);
                  writedata  <= w_pick_b ? b_writedata  : a_writedata;
                  byteenable <= w_pick_b ? b_byteenable : a_byteenable;
                  r_win      <= w_pick_b;
                  r_state    <= ST_BUSY;
               end else begin
                  address    <= '0;
                  read       <= 1'b0;
                  write      <= 1'b0;
                  writedata  <= '0;
                  byteenable <= '0;
               end
            end
            ST_BUSY: begin
               if (!waitrequest || w_timeout) begin
                  if (r_win) begin
                     b_readdata <= w_capture;
                     b_ack      <= 1'b1;
                  end else begin
                     a_readdata <= w_capture;
                     a_ack      <= 1'b1;
                  end
                  read       <= 1'b0;
                  write      <= 1'b0;
                  byteenable <= '0;
                  r_ptr      <= ~r_win;
                  r_state    <= ST_DONE;
               end
            end
            // Ack cycle: the winner still holds its request, so no arbitration here
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sextium_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sextium_avalon_arbiter
// Description : Self-checking bench for sextium_avalon_arbiter: directed
//               scenarios plus randomized traffic against a transaction-level
//               reference model of the arbitration and Avalon handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sextium_avalon_arbiter;

`ifdef SEXTIUM_ARB_TIMEOUT_EN
   localparam int TO_CYCLES = 8;
`else
   localparam int TO_CYCLES = 1024;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] a_address = '0, b_address = '0;
   logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
   logic [31:0] a_writedata = '0, b_writedata = '0;
   logic [3:0]  a_byteenable = '0, b_byteenable = '0;
   logic [31:0] a_readdata, b_readdata;
   logic        a_ack, b_ack;
   logic [31:0] address, writedata;
   logic        read, write;
   logic [3:0]  byteenable;
   logic [31:0] readdata = '0;
   logic        waitrequest = 1'b0;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sextium_avalon_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYCLES)
   ) dut (
      .clk(clk), .reset(reset),
      .a_address(a_address), .a_read(a_read), .a_write(a_write),
      .a_writedata(a_writedata), .a_byteenable(a_byteenable),
      .a_readdata(a_readdata), .a_ack(a_ack),
      .b_address(b_address), .b_read(b_read), .b_write(b_write),
      .b_writedata(b_writedata), .b_byteenable(b_byteenable),
      .b_readdata(b_readdata), .b_ack(b_ack),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
      .err(err)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      a_read = 0; a_write = 0; b_read = 0; b_write = 0;
      a_address = '0; b_address = '0; a_writedata = '0; b_writedata = '0;
      a_byteenable = '0; b_byteenable = '0; waitrequest = 0; readdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({read, write, address, writedata, byteenable} !== 70'd0) begin
         errors++;
         $display("FAIL reset_master got=%h exp=0", {read, write, address, writedata, byteenable});
      end
      checks++;
      if ({a_ack, b_ack, a_readdata, b_readdata} !== 66'd0) begin
         errors++;
         $display("FAIL reset_req got=%h exp=0", {a_ack, b_ack, a_readdata, b_readdata});
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got=%b exp=0", err);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({read, write, a_ack, b_ack} !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=0000", {read, write, a_ack, b_ack});
      end
   endtask

   task automatic test_single_read();
      int nreads = 0;
      do_reset();
      @(negedge clk);
      a_address = 32'h21000; a_read = 1; waitrequest = 0; readdata = 32'h1234;
      @(negedge clk);
      nreads += int'(read);
      checks++;
      if (read !== 1'b1 || write !== 1'b0 || address !== 32'h21000) begin
         errors++;
         $display("FAIL single_read_issue got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=21000", read, write, address);
      end
      @(negedge clk);
      nreads += int'(read);
      checks++;
      if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_readdata !== 32'h1234) begin
         errors++;
         $display("FAIL single_read_ack got ack=%b/%b data=%h exp ack=1/0 data=1234", a_ack, b_ack, a_readdata);
      end
      a_read = 0;
      repeat (4) begin
         @(negedge clk);
         nreads += int'(read);
      end
      checks++;
      if (nreads !== 1) begin
         errors++;
         $display("FAIL single_read_count got=%0d exp=1", nreads);
      end
   endtask

   task automatic test_both_write();
      int acks_a = 0, acks_b = 0, start_a = -1, start_b = -1;
      logic [31:0] wd_seen [2];
      do_reset();
      @(negedge clk);
      a_address = 32'h100; a_write = 1; a_writedata = 32'h11; a_byteenable = 4'hF;
      b_address = 32'h200; b_write = 1; b_writedata = 32'h22; b_byteenable = 4'h3;
      waitrequest = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (write && start_a < 0) begin start_a = c; wd_seen[0] = writedata; end
         else if (write && start_a >= 0 && start_b < 0 && c > start_a + 1) begin
            start_b = c; wd_seen[1] = writedata;
         end
         if (a_ack) begin acks_a++; a_write = 0; end
         if (b_ack) begin acks_b++; b_write = 0; end
      end
      checks++;
      if (start_a !== 1 || wd_seen[0] !== 32'h11) begin
         errors++;
         $display("FAIL both_write_first got start=%0d data=%h exp start=1 data=11", start_a, wd_seen[0]);
      end
      checks++;
      if (start_b !== start_a + 3 || wd_seen[1] !== 32'h22) begin
         errors++;
         $display("FAIL both_write_second got start=%0d data=%h exp start=%0d data=22", start_b, wd_seen[1], start_a + 3);
      end
      checks++;
      if (acks_a !== 1 || acks_b !== 1) begin
         errors++;
         $display("FAIL both_write_acks got a=%0d b=%0d exp 1/1", acks_a, acks_b);
      end
   endtask

   task automatic test_alternate();
      int n = 0;
      do_reset();
      @(negedge clk);
      a_address = 32'hA0; a_read = 1; b_address = 32'hB0; b_read = 1; waitrequest = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            checks++;
            if ({a_ack, b_ack} !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
               errors++;
               $display("FAIL alternate_grant n=%0d got ack a/b=%b%b exp=%s", n, a_ack, b_ack, (n % 2 == 0) ? "A" : "B");
            end
            n++;
         end
      end
      a_read = 0; b_read = 0;
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL alternate_count got=%0d exp=6", n);
      end
   endtask

   task automatic test_waitrequest();
      logic [31:0] addr = 32'h0BAD0040;
      logic bad = 1'b0;
      do_reset();
      @(negedge clk);
      b_address = addr; b_read = 1; waitrequest = 1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (read !== 1'b1 || address !== addr || a_ack !== 1'b0 || b_ack !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL wait_stable got rd=%b addr=%h ack=%b%b exp rd=1 addr=%h ack=00", read, address, a_ack, b_ack, addr);
      end
      waitrequest = 0; readdata = 32'hCAFEF00D;
      @(negedge clk);
      checks++;
      if (b_ack !== 1'b1 || a_ack !== 1'b0 || b_readdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL wait_ack got ack=%b%b data=%h exp ack=01 data=cafef00d", a_ack, b_ack, b_readdata);
      end
      b_read = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_busy();
      do_reset();
      @(negedge clk);
      a_address = 32'h400; a_read = 1; b_address = 32'h800; b_read = 1; waitrequest = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (read !== 1'b1 || address !== 32'h400) begin
         errors++;
         $display("FAIL rstbusy_pre got rd=%b addr=%h exp rd=1 addr=400", read, address);
      end
      #2 reset = 0;
      #1;
      checks++;
      if ({read, write, a_ack, b_ack} !== 4'd0) begin
         errors++;
         $display("FAIL rstbusy_drop got=%b exp=0000", {read, write, a_ack, b_ack});
      end
      a_read = 0;
      @(negedge clk);
      reset = 1; waitrequest = 0;
      @(negedge clk);
      checks++;
      if (read !== 1'b1 || address !== 32'h800 || a_ack !== 1'b0) begin
         errors++;
         $display("FAIL rstbusy_regrant got rd=%b addr=%h a_ack=%b exp rd=1 addr=800 a_ack=0", read, address, a_ack);
      end
      @(negedge clk);
      checks++;
      if (b_ack !== 1'b1 || a_ack !== 1'b0) begin
         errors++;
         $display("FAIL rstbusy_ack got ack=%b%b exp=01", a_ack, b_ack);
      end
      b_read = 0;
   endtask

`ifdef SEXTIUM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int cnt = 0;
      do_reset();
      @(negedge clk);
      a_address = 32'h77; a_read = 1; waitrequest = 1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         cnt++;
         if (a_ack) break;
      end
      checks++;
      if (cnt !== 9 || a_readdata !== 32'hFFFFFFFF || err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_abort got cyc=%0d data=%h err=%b exp cyc=9 data=ffffffff err=1", cnt, a_readdata, err);
      end
      a_read = 0; waitrequest = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (err !== 1'b1 || read !== 1'b0) begin
         errors++;
         $display("FAIL timeout_sticky got err=%b rd=%b exp err=1 rd=0", err, read);
      end
   endtask
`else
   task automatic test_timeout();
      logic bad = 1'b0;
      do_reset();
      @(negedge clk);
      a_address = 32'h77; a_read = 1; waitrequest = 1;
      repeat (40) begin
         @(negedge clk);
         if (read !== 1'b1 || a_ack !== 1'b0 || err !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL nowatchdog_wait got rd=%b ack=%b err=%b exp rd=1 ack=0 err=0", read, a_ack, err);
      end
      waitrequest = 0; readdata = 32'h5A5A;
      @(negedge clk);
      checks++;
      if (a_ack !== 1'b1 || a_readdata !== 32'h5A5A) begin
         errors++;
         $display("FAIL nowatchdog_ack got ack=%b data=%h exp ack=1 data=5a5a", a_ack, a_readdata);
      end
      a_read = 0;
   endtask
`endif

   // Randomized traffic. Model: each requester holds one request until acked;
   // a grant goes to the sole pending requester, or when both pend to the one
   // not served by the previous completion (A after reset). The slave side
   // completes a transaction on the first edge with waitrequest low, and the
   // ack follows one cycle later; afterwards one quiet cycle precedes the
   // next grant.
   task automatic test_random();
      logic        pend [2];
      logic        drop [2];
      int          kind [2];      // 0 read, 1 write, 2 read+write (issued as read)
      logic [31:0] addr [2], wd [2], exp_rd [2];
      logic [3:0]  be [2];
      logic        ptr;           // 0 = A favoured
      int          phase;         // 0 quiet, 1 new grant, 2 stalled, 3 ack
      int          cur, streak, done_cnt;
      int          done_per [2];
      logic [31:0] drv_rd, obs_rd;
      logic [71:0] exp_bus, obs_bus;
      logic        obs_ack;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         pend[i] = 0; drop[i] = 0; kind[i] = 0; exp_rd[i] = '0; done_per[i] = 0;
         addr[i] = '0; wd[i] = '0; be[i] = '0;
      end
      ptr = 0; phase = 0; cur = 0; streak = 0; done_cnt = 0; drv_rd = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         if (phase == 1)
            cur = (pend[0] && pend[1]) ? int'(ptr) : (pend[1] ? 1 : 0);
         obs_bus = {read, write, address, writedata, byteenable, b_ack, a_ack};
         if (phase == 1 || phase == 2) begin
            exp_bus = {kind[cur] != 1, kind[cur] == 1, addr[cur], wd[cur], be[cur], 2'b00};
            checks++;
            if (obs_bus !== exp_bus) begin
               errors++;
               $display("FAIL random_busy cyc=%0d got=%h exp=%h", cyc, obs_bus, exp_bus);
            end
         end else if (phase == 3) begin
            obs_ack = (cur == 1) ? b_ack : a_ack;
            obs_rd  = (cur == 1) ? b_readdata : a_readdata;
            exp_rd[cur] = (kind[cur] == 1) ? 32'd0 : drv_rd;
            checks++;
            if (obs_ack !== 1'b1 || {a_ack, b_ack} === 2'b11 || obs_rd !== exp_rd[cur] || {read, write} !== 2'b00) begin
               errors++;
               $display("FAIL random_ack cyc=%0d req=%0d got ack=%b%b rw=%b%b data=%h exp data=%h", cyc, cur, a_ack, b_ack, read, write, obs_rd, exp_rd[cur]);
            end
            ptr = (cur == 0);
            pend[cur] = 0; drop[cur] = 1;
            done_cnt++; done_per[cur]++;
         end else begin
            checks++;
            if ({read, write, a_ack, b_ack, err} !== 5'd0) begin
               errors++;
               $display("FAIL random_quiet cyc=%0d got rw/ack/err=%b exp=00000", cyc, {read, write, a_ack, b_ack, err});
            end
         end
         checks++;
         if (a_readdata !== exp_rd[0] || b_readdata !== exp_rd[1]) begin
            errors++;
            $display("FAIL random_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, a_readdata, b_readdata, exp_rd[0], exp_rd[1]);
         end
         // slave response for the coming edge
         waitrequest = (streak >= 4) ? 1'b0 : ($urandom_range(0, 9) < 3);
         streak = waitrequest ? streak + 1 : 0;
         drv_rd = $urandom;
         readdata = drv_rd;
         // requesters
         for (int i = 0; i < 2; i++) begin
            if (drop[i]) drop[i] = 0;
            else if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1; kind[i] = $urandom_range(0, 2);
               addr[i] = $urandom; wd[i] = $urandom; be[i] = 4'($urandom_range(0, 15));
            end
         end
         a_read = pend[0] && kind[0] != 1; a_write = pend[0] && kind[0] != 0;
         a_address = addr[0]; a_writedata = wd[0]; a_byteenable = be[0];
         b_read = pend[1] && kind[1] != 1; b_write = pend[1] && kind[1] != 0;
         b_address = addr[1]; b_writedata = wd[1]; b_byteenable = be[1];
         case (phase)
            1, 2:    phase = waitrequest ? 2 : 3;
            3:       phase = 0;
            default: phase = (pend[0] || pend[1]) ? 1 : 0;
         endcase
      end
      a_read = 0; a_write = 0; b_read = 0; b_write = 0; waitrequest = 0;
      checks++;
      if (done_cnt < 60 || done_per[0] < 20 || done_per[1] < 20) begin
         errors++;
         $display("FAIL random_progress got total=%0d a=%0d b=%0d exp >=60 with >=20 each", done_cnt, done_per[0], done_per[1]);
      end
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_single_read();
      test_reset();
      test_both_write();
      test_alternate();
      test_waitrequest();
      test_reset_busy();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
